instruction_predecode_queue: RTL
================================

// Module: instruction_predecode_queue
// PURPOSE
//  Parametrised fetch-to-decode buffer: accepts up to FETCH_WIDTH instructions/cycle from fetch,
//  predecodes each into an instruction class at push time, and issues one entry/cycle in order to
//  ID over valid/ready. Provides MDU interlock, flush on redirect, halt on undefined instruction.
// PARAMETERS
//  DEPTH        8   queue entries; power of 2, >= 2*FETCH_WIDTH
//  FETCH_WIDTH  2   instructions per fetch group, 1..4
//  CNT_W        $clog2(DEPTH+1)        occupancy width (derived, localparam)
//  FC_W         $clog2(FETCH_WIDTH+1)  fetch_count width (derived, localparam)
// PORTS
//  clk            in   1               clock, rising edge
//  reset_n        in   1               asynchronous, active-low reset
//  fetch_valid    in   1               fetch group present
//  fetch_count    in   FC_W            valid slots in group, contiguous from slot 0
//  fetch_instr    in   32*FETCH_WIDTH  slot i at [32*i +: 32]
//  fetch_pc       in   32              PC of slot 0; slot i PC = fetch_pc + 4*i
//  fetch_ready    out  1               queue can take a full group this cycle
//  issue_valid    out  1               head entry presented to ID
//  issue_ready    in   1               ID accepts head
//  issue_instr    out  32              head instruction word
//  issue_pc       out  32              head PC
//  issue_class    out  InstrClass      head predecode class
//  issue_undefined out 1               head class == CLS_UNDEFINED
//  mdu_busy       in   1               MDU computing; blocks MDU-class issue
//  flush          in   1               discard all entries (branch/jump redirect)
//  occupancy      out  CNT_W           valid entries
// BEHAVIOUR
//  - Reset (async, reset_n=0): rd/wr pointers 0, occupancy 0, state RUN, issue_valid 0,
//    fetch_ready 1, issue_instr/pc 0, issue_class CLS_NOP. Mid-operation reset discards all.
//  - Storage: DEPTH x {instr, pc, class}; pointers log2(DEPTH)+1 bits, extra MSB distinguishes
//    full/empty; index wraps modulo DEPTH.
//  - Push: fetch_valid & fetch_ready & state==RUN & !flush; writes fetch_count entries at wr_ptr,
//    wr_ptr += fetch_count. fetch_count 0 = no-op; fetch_count > FETCH_WIDTH is illegal (assert).
//  - fetch_ready = (state==RUN) & (DEPTH - occupancy >= FETCH_WIDTH); from registered occupancy,
//    ignores same-cycle pop (conservative, no comb path from issue_ready).
//  - Latency: pushed at edge N -> visible on issue_* after edge N (cycle N+1); issue_* driven
//    combinationally from head storage, no bypass from fetch.
//  - Issue: issue_valid = (state==RUN) & occupancy!=0 & !(mdu_busy & head class in
//    {CLS_MDU_START, CLS_MDU_MOVE}). Pop on issue_valid & issue_ready; rd_ptr += 1.
//  - Simultaneous push+pop: occupancy += fetch_count - 1; legal at any occupancy fetch_ready allows.
//  - flush: highest priority; next edge rd_ptr=wr_ptr, occupancy 0, state RUN; same-cycle push and
//    pop both dropped (ID must ignore issue handshake in flush cycle).
//  - FSM: RUN -> HALTED when a CLS_UNDEFINED entry pops; HALTED: issue_valid 0, fetch_ready 0,
//    contents held; HALTED -> RUN only on flush. reset -> RUN.
//  - Predecode (per slot, comb): opcode/funct/rt -> CLS_NOP (all-zero word), CLS_ALU (R-type arith/
//    logic/shift, I-type imm, LUI), CLS_BRANCH (BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ), CLS_JUMP (J/JAL/JR/
//    JALR), CLS_LOAD (LB/LBU/LH/LHU/LW), CLS_STORE (SB/SH/SW), CLS_MDU_START (MULT/MULTU/DIV/DIVU),
//    CLS_MDU_MOVE (MFHI/MFLO/MTHI/MTLO), CLS_SYSCALL, else CLS_UNDEFINED.
// STRUCTURE
//  - Shared MIPS definitions package: InstrClass enum (4 bits) and opcode/funct constants; no new
//    local copies of encodings.
//  - Sub-module instruction_predecoder (comb, 32-bit in -> InstrClass), FETCH_WIDTH instances.
//  - Top: storage array, pointer/occupancy regs, 2-state FSM, issue gating.
// TESTING (DEPTH=8, FETCH_WIDTH=2)
//  1 Fill/wrap: 4 groups of 2 from pc 0x3000, issue_ready=0 -> occupancy 8, fetch_ready 0; then
//    issue_ready=1 pops pc 0x3000..0x301C in order; refill 0x4000.. after wrap pops in order.
//  2 Push+pop same cycle at occupancy 5, fetch_count=2 -> occupancy 6; fetch_count=1 -> stays 5.
//  3 MDU interlock: head 0x00004012 (MFLO), mdu_busy=1 -> issue_valid 0, class CLS_MDU_MOVE;
//    drop mdu_busy -> issue_valid 1 same cycle; ADDU head unaffected by mdu_busy.
//  4 Undefined: head 0xFC000000 -> issue_undefined 1; after pop issue_valid 0, fetch_ready 0 with
//    3 entries still held; flush -> occupancy 0, state RUN, fetch_ready 1.
//  5 Flush with fetch_valid=1, fetch_count=2 at occupancy 4 -> next cycle occupancy 0, no entry.
//  6 reset_n low mid-stream (occupancy 6) -> immediately occupancy 0, issue_valid 0, fetch_ready 1.

Source files
------------

// File: rtl/instruction_predecode_queue_pkg.sv
// Shared MIPS-I encodings and predecode class definitions for the fetch-to-decode queue.
// Every block that decodes opcode/funct/rt fields imports these constants.
package instruction_predecode_queue_pkg;

    typedef enum logic [3:0] {
        CLS_NOP       = 4'd0,
        CLS_ALU       = 4'd1,
        CLS_BRANCH    = 4'd2,
        CLS_JUMP      = 4'd3,
        CLS_LOAD      = 4'd4,
        CLS_STORE     = 4'd5,
        CLS_MDU_START = 4'd6,
        CLS_MDU_MOVE  = 4'd7,
        CLS_SYSCALL   = 4'd8,
        CLS_UNDEFINED = 4'd9
    } InstrClass;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } queue_state_t;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL function codes, instr[5:0]
    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_SLLV    = 6'h04;
    localparam logic [5:0] FN_SRLV    = 6'h06;
    localparam logic [5:0] FN_SRAV    = 6'h07;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;

    // REGIMM rt selectors, instr[20:16]
    localparam logic [4:0] RT_BLTZ    = 5'h00;
    localparam logic [4:0] RT_BGEZ    = 5'h01;

endpackage

// File: rtl/instruction_predecode_queue_predecoder.sv
// Combinational MIPS-I predecoder: maps one 32-bit instruction word to its InstrClass.
module instruction_predecoder
    import instruction_predecode_queue_pkg::*;
(
    input  logic [31:0] i_instr,
    output InstrClass   o_class
);

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic [4:0] w_rt;

    assign w_opcode = i_instr[31:26];
    assign w_funct  = i_instr[5:0];
    assign w_rt     = i_instr[20:16];

    always_comb begin
        o_class = CLS_UNDEFINED;
        // The all-zero word (SLL $0,$0,0) is the canonical NOP and takes precedence over ALU.
        if (i_instr == 32'h0000_0000) begin
            o_class = CLS_NOP;
        end else begin
            case (w_opcode)
                OP_SPECIAL: begin
                    case (w_funct)
                        FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                        FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                        FN_XOR, FN_NOR, FN_SLT, FN_SLTU:
                            o_class = CLS_ALU;
                        FN_JR, FN_JALR:
                            o_class = CLS_JUMP;
                        FN_SYSCALL:
                            o_class = CLS_SYSCALL;
                        FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO:
                            o_class = CLS_MDU_MOVE;
                        FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:
                            o_class = CLS_MDU_START;
                        default:
                            o_class = CLS_UNDEFINED;
                    endcase
                end
                OP_REGIMM: begin
                    if (w_rt == RT_BLTZ || w_rt == RT_BGEZ) begin
                        o_class = CLS_BRANCH;
                    end
                end
                OP_J, OP_JAL:
                    o_class = CLS_JUMP;
                OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
                    o_class = CLS_BRANCH;
                OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                    o_class = CLS_ALU;
                OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:
                    o_class = CLS_LOAD;
                OP_SB, OP_SH, OP_SW:
                    o_class = CLS_STORE;
                default:
                    o_class = CLS_UNDEFINED;
            endcase
        end
    end

endmodule

// File: rtl/instruction_predecode_queue.sv
// Fetch-to-decode queue: multi-slot push with predecode, single in-order issue, MDU interlock,
// flush on redirect and halt after an undefined instruction is issued.
module instruction_predecode_queue
    import instruction_predecode_queue_pkg::*;
#(
    parameter  int DEPTH       = 8,
    parameter  int FETCH_WIDTH = 2,
    localparam int CNT_W       = $clog2(DEPTH + 1),
    localparam int FC_W        = $clog2(FETCH_WIDTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      fetch_valid,
    input  logic [FC_W-1:0]           fetch_count,
    input  logic [32*FETCH_WIDTH-1:0] fetch_instr,
    input  logic [31:0]               fetch_pc,
    output logic                      fetch_ready,
    output logic                      issue_valid,
    input  logic                      issue_ready,
    output logic [31:0]               issue_instr,
    output logic [31:0]               issue_pc,
    output InstrClass                 issue_class,
    output logic                      issue_undefined,
    input  logic                      mdu_busy,
    input  logic                      flush,
    output logic [CNT_W-1:0]          occupancy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    queue_state_t      r_state;
    queue_state_t      w_state_next;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_occ;

    logic [31:0]       r_mem_instr [DEPTH];
    logic [31:0]       r_mem_pc    [DEPTH];
    InstrClass         r_mem_class [DEPTH];

    InstrClass         w_slot_class [FETCH_WIDTH];
    logic [IDX_W-1:0]  w_slot_idx   [FETCH_WIDTH];
    logic [FETCH_WIDTH-1:0] w_slot_en;

    logic [IDX_W-1:0]  w_rd_idx;
    InstrClass         w_head_class;
    logic              w_head_mdu;
    logic [CNT_W-1:0]  w_free;
    logic              w_fetch_ready;
    logic              w_issue_valid;
    logic              w_push;
    logic              w_pop;
    logic [FC_W-1:0]   w_push_cnt;

    // One predecoder per fetch slot; slot index wraps naturally because DEPTH is a power of 2.
    generate
        for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_slot
            instruction_predecoder u_predecoder (
                .i_instr (fetch_instr[32*gi +: 32]),
                .o_class (w_slot_class[gi])
            );
            assign w_slot_idx[gi] = r_wr_ptr[IDX_W-1:0] + IDX_W'(gi);
            assign w_slot_en[gi]  = w_push && (FC_W'(gi) < fetch_count);
        end
    endgenerate

    assign w_rd_idx     = r_rd_ptr[IDX_W-1:0];
    assign w_head_class = r_mem_class[w_rd_idx];
    assign w_head_mdu   = (w_head_class == CLS_MDU_START) || (w_head_class == CLS_MDU_MOVE);
    assign w_free       = CNT_W'(DEPTH) - r_occ;

    always_comb begin
        w_state_next  = r_state;
        w_fetch_ready = 1'b0;
        w_issue_valid = 1'b0;
        case (r_state)
            ST_RUN: begin
                // Registered occupancy only: a same-cycle pop never widens fetch_ready.
                w_fetch_ready = (w_free >= CNT_W'(FETCH_WIDTH));
                w_issue_valid = (r_occ != '0) && !(mdu_busy && w_head_mdu);
                if (w_issue_valid && issue_ready && (w_head_class == CLS_UNDEFINED)) begin
                    w_state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                w_state_next = ST_HALTED;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
        if (flush) begin
            w_state_next = ST_RUN;
        end
    end

    assign w_push     = fetch_valid && w_fetch_ready && !flush;
    assign w_pop      = w_issue_valid && issue_ready && !flush;
    assign w_push_cnt = w_push ? fetch_count : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else if (flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(fetch_count);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_occ <= r_occ + CNT_W'(w_push_cnt) - CNT_W'(w_pop);
        end
    end

    // Storage is cleared on reset so the head reads as a zero-PC NOP while empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_instr[i] <= '0;
                r_mem_pc[i]    <= '0;
                r_mem_class[i] <= CLS_NOP;
            end
        end else begin
            for (int s = 0; s < FETCH_WIDTH; s++) begin
                if (w_slot_en[s]) begin
                    r_mem_instr[w_slot_idx[s]] <= fetch_instr[32*s +: 32];
                    r_mem_pc[w_slot_idx[s]]    <= fetch_pc + 32'(4 * s);
                    r_mem_class[w_slot_idx[s]] <= w_slot_class[s];
                end
            end
        end
    end

    assign fetch_ready     = w_fetch_ready;
    assign issue_valid     = w_issue_valid;
    assign issue_instr     = r_mem_instr[w_rd_idx];
    assign issue_pc        = r_mem_pc[w_rd_idx];
    assign issue_class     = w_head_class;
    assign issue_undefined = (w_head_class == CLS_UNDEFINED);
    assign occupancy       = r_occ;

    a_fetch_count_legal: assert property (
        @(posedge clk) disable iff (!reset_n)
        fetch_valid |-> (fetch_count <= FC_W'(FETCH_WIDTH))
    );

endmodule
